// File: rtl/uart_tx.sv
// uart_tx: transmit-side UART serializer.
// Pulls one byte per frame from a synchronous FIFO read port and shifts it out
// as start bit, DATA_WIDTH data bits (LSB first), optional parity and 1 or 2
// stop bits. Every output is a register; the FSM state is exposed on STATEo.
//
// FIFO handshake: RDo is a single-cycle strobe, raised only when EMPTYi was
// sampled low in IDLE; the FIFO presents the word on DATAi in the cycle after
// RDo, which is exactly when the FSM sits in LOAD and captures it. DATAi is
// ignored at every other time.
module uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  CLKi,
  input  logic                  RSTi,
  input  logic                  ENi,
  input  logic                  EMPTYi,
  output logic                  RDo,
  input  logic [DATA_WIDTH-1:0] DATAi,
  output logic                  TXo,
  output logic                  BUSYo,
  output logic                  DONEo,
  output logic [2:0]            STATEo
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);

  // Reject parameter combinations the serializer cannot honour.
  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_PARITY = 3'd5,
    S_STOP   = 3'd6
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      baud_cnt;
  logic [IDX_W-1:0]      bit_idx;
  logic                  stop_idx;
  logic [DATA_WIDTH-1:0] shift;
  logic                  par_bit;
  logic                  bit_end;

  // Last cycle of the bit currently on the line.
  assign bit_end = (baud_cnt == CNT_LAST);

  assign STATEo = state;

  // Frame sequencer: state, counters, shift register and all registered outputs.
  always_ff @(posedge CLKi or posedge RSTi) begin
    if (RSTi) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shift    <= '0;
      par_bit  <= 1'b0;
      TXo      <= 1'b1;
      RDo      <= 1'b0;
      BUSYo    <= 1'b0;
      DONEo    <= 1'b0;
    end else begin
      RDo   <= 1'b0;
      DONEo <= 1'b0;
      case (state)
        S_IDLE: begin
          TXo      <= 1'b1;
          baud_cnt <= '0;
          bit_idx  <= '0;
          stop_idx <= 1'b0;
          if (ENi && !EMPTYi) begin
            state <= S_FETCH;
            RDo   <= 1'b1;
            BUSYo <= 1'b1;
          end
        end
        S_FETCH: begin
          // FIFO is updating DATAi on this edge; capture it next cycle.
          state <= S_LOAD;
        end
        S_LOAD: begin
          shift    <= DATAi;
          par_bit  <= (PARITY == 2) ? ~(^DATAi) : (^DATAi);
          TXo      <= 1'b0;
          baud_cnt <= '0;
          state    <= S_START;
        end
        S_START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            TXo      <= shift[0];
            shift    <= shift >> 1;
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == IDX_LAST) begin
              bit_idx <= '0;
              if (PARITY != 0) begin
                TXo   <= par_bit;
                state <= S_PARITY;
              end else begin
                TXo      <= 1'b1;
                stop_idx <= 1'b0;
                state    <= S_STOP;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              TXo     <= shift[0];
              shift   <= shift >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            baud_cnt <= '0;
            TXo      <= 1'b1;
            stop_idx <= 1'b0;
            state    <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (stop_idx == STOP_LAST) begin
              stop_idx <= 1'b0;
              DONEo    <= 1'b1;
              BUSYo    <= 1'b0;
              state    <= S_IDLE;
            end else begin
              stop_idx <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          TXo   <= 1'b1;
          BUSYo <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
